disp_arbiter: RTL and testbench
===============================

Name: disp_arbiter

Overview:
- Time-shares the single 4-digit seven-segment display between up to NUM_SRC 16-bit requesters (CPU result, PC, debug registers).
- Grants one source at a time, round-robin, for a programmable dwell period.
- Forwards the granted source's live value to the seven-segment driver's displayed_number input.
- Sits in the top level between the multicycle core outputs and the display driver.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DWELL_CYCLES, 100000000, clock cycles each grant is held (1 s at 100 MHz).
- BLANK_CYCLES, 10000000, blank gap length; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_SRC  level request per source; bit i high = source i wants display time.
- src_data  in  16*NUM_SRC  packed values; source i occupies bits [16*i+15:16*i].
- lock  in  1  high freezes the current grant; dwell counter holds.
- grant  out  NUM_SRC  one-hot grant; all zero when idle.
- disp_value  out  16  value to the display driver.
- disp_src  out  $clog2(NUM_SRC)  index of the granted source.
- disp_valid  out  1  high while a source is granted.
- done  out  NUM_SRC  one-cycle pulse on bit i when source i's dwell expires normally.

Behaviour:
- Reset (rst low, async): grant=0, disp_value=16'h0000, disp_src=0, disp_valid=0, done=0, dwell counter=0, state=IDLE. RR pointer = NUM_SRC-1, so source 0 has first priority.
- Round-robin pick (combinational): the first requesting index scanning from ptr+1 upward, with wrap. The pointer updates to the granted index on every new grant.
- IDLE:
  - disp_valid=0; disp_value holds its last value.
  - If any req is high at a clock edge, on that same edge: state→SHOW, grant=pick, disp_src=pick, counter=0.
  - Latency: 1 cycle from req to grant.
- SHOW:
  - disp_value is re-sampled every cycle from the granted src_data slice, so the display tracks a changing CPU output with 1-cycle delay.
  - disp_valid=1.
  - Counter increments each cycle unless lock=1 (lock holds the counter and grant indefinitely).
- Dwell expiry (counter==DWELL_CYCLES-1, lock=0):
  - done[granted] pulses for 1 cycle.
  - On the same edge, re-arbitrate: if any req → new grant (may be the same source if it is the only requester), counter=0; else → IDLE, grant=0.
- Requester drop: if req[granted] falls in SHOW, regardless of lock:
  - Next edge releases the grant and re-arbitrates immediately, as at expiry.
  - No done pulse.
- Requests from non-granted sources never pre-empt the current grant.
- Simultaneous expiry and drop of the granted source: treated as a drop; no done pulse.
- The counter width is $clog2(DWELL_CYCLES). The counter never exceeds DWELL_CYCLES-1.
- grant is always one-hot or zero.
- Reset mid-SHOW returns to the reset values immediately (asynchronously); no done pulse is produced.

Optional Feature:
- Macro DISP_ARB_BLANK_EN.
- When defined:
  - A BLANK state is inserted between consecutive grants whenever the source index changes.
  - For BLANK_CYCLES cycles: disp_value=16'h0000, disp_valid=0, grant=0.
  - The next grant is chosen at BLANK exit from the req values current at that time.
  - A same-source re-grant skips BLANK.
  - Reset inside BLANK → IDLE.
- When undefined: no BLANK state; switches happen back-to-back as described in Behaviour, and BLANK_CYCLES is ignored.

Decomposition:
- Package disp_arb_pkg holds:
  - state enum (IDLE, SHOW, BLANK);
  - DATA_W=16;
  - a helper function that extracts the 16-bit slice for an index.
- One sub-module, rr_picker: purely combinational, parameterised by NUM_SRC. Inputs are req and ptr; outputs are pick index and any_req. It is reusable by other arbiters.

Test Plan:
All scenarios use DWELL_CYCLES=4, NUM_SRC=4, BLANK_CYCLES=2 with DISP_ARB_BLANK_EN undefined unless stated.
1. Reset: rst=0 with req=4'hF → grant=0, disp_value=0x0000, disp_valid=0, done=0. Release rst → grant=4'b0001 one edge later.
2. Single requester: req=4'b0100, src2=0x1234 → grant=4'b0100, disp_value=0x1234 one cycle after grant. done[2] pulses at cycle 4, then the same source is re-granted with no gap.
3. Rotation: req=4'hF, sources 0x000A/0x000B/0x000C/0x000D → disp_value sequence A,B,C,D,A, each held 4 cycles; done pulses in order 0,1,2,3.
4. Drop: source 1 granted; deassert req[1] after 2 cycles → next edge grant=4'b0100. done[1] never pulses.
5. Lock: lock=1 for 20 cycles while source 0 is granted → grant is held and done=0. Lock release → expiry after the remaining count, then grant moves to source 1.
6. Blank (macro defined): switch from source 0 to source 1 → 2 cycles with disp_valid=0 and disp_value=0 before grant=4'b0010. Assert rst mid-BLANK → reset values.

Source files
------------

// File: rtl/disp_arb_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
// Optional blank gap between grants is enabled with DISP_ARB_BLANK_EN.
package disp_arb_pkg;

  localparam int DATA_W  = 16;
  localparam int MAX_SRC = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } state_t;

  function automatic logic [DATA_W-1:0] src_slice(
    input logic [MAX_SRC*DATA_W-1:0] data,
    input logic [IDX_W-1:0]          idx
  );
    return data[{idx, 4'b0000} +: DATA_W];
  endfunction

endpackage

// File: rtl/disp_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester above ptr, with wrap.
// Reusable by any arbiter that keeps its own last-grant pointer.
module rr_picker #(
  parameter int NUM_SRC = 4,
  parameter int SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SW-1:0]      ptr,
  output logic [SW-1:0]      pick,
  output logic               any_req
);

  logic [SW:0] w_t;

  // Scan from the farthest candidate down so the nearest one wins.
  always_comb begin
    pick = ptr;
    w_t  = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      w_t = {1'b0, ptr} + (SW+1)'(k);
      if (w_t >= (SW+1)'(NUM_SRC))
        w_t = w_t - (SW+1)'(NUM_SRC);
      if (req[w_t[SW-1:0]])
        pick = w_t[SW-1:0];
    end
    any_req = |req;
  end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin time-sharing of the 4-digit display between requesters.
// Define DISP_ARB_BLANK_EN to insert a blank gap when the source changes.
module disp_arbiter
  import disp_arb_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 100000000,
  parameter int BLANK_CYCLES = 10000000,
  parameter int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        req,
  input  logic [DATA_W*NUM_SRC-1:0] src_data,
  input  logic                      lock,
  output logic [NUM_SRC-1:0]        grant,
  output logic [DATA_W-1:0]         disp_value,
  output logic [SW-1:0]             disp_src,
  output logic                      disp_valid,
  output logic [NUM_SRC-1:0]        done
);

  // One counter serves both dwell and blank periods.
  localparam int SPAN = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (SPAN > 1) ? $clog2(SPAN) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
`ifdef DISP_ARB_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`endif

  state_t                     r_state;
  logic [NUM_SRC-1:0]         r_grant;
  logic [SW-1:0]              r_src;
  logic [SW-1:0]              r_ptr;
  logic [CW-1:0]              r_cnt;
  logic [DATA_W-1:0]          r_value;
  logic                       r_valid;
  logic [NUM_SRC-1:0]         r_done;

  logic [SW-1:0]              w_pick;
  logic                       w_any;
  logic [NUM_SRC-1:0]         w_pick_oh;
  logic [MAX_SRC*DATA_W-1:0]  w_ext;
  logic [IDX_W-1:0]           w_idx;
  logic                       w_drop;
  logic                       w_exp;

  rr_picker #(
    .NUM_SRC (NUM_SRC),
    .SW      (SW)
  ) u_pick (
    .req     (req),
    .ptr     (r_ptr),
    .pick    (w_pick),
    .any_req (w_any)
  );

  always_comb begin
    w_pick_oh         = '0;
    w_pick_oh[w_pick] = 1'b1;
    w_ext             = '0;
    w_ext[DATA_W*NUM_SRC-1:0] = src_data;
    w_idx             = '0;
    w_idx[SW-1:0]     = r_src;
  end

  assign w_drop = ~|(req & r_grant);
  assign w_exp  = (r_cnt == DWELL_LAST) && !lock;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_src   <= '0;
      r_ptr   <= SW'(NUM_SRC - 1);
      r_cnt   <= '0;
      r_value <= '0;
      r_valid <= 1'b0;
      r_done  <= '0;
    end else begin
      r_done <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= SHOW;
            r_grant <= w_pick_oh;
            r_src   <= w_pick;
            r_ptr   <= w_pick;
            r_cnt   <= '0;
            r_valid <= 1'b1;
          end
        end
        SHOW: begin
          r_value <= src_slice(w_ext, w_idx);
          if (w_drop || w_exp) begin
            // A drop wins over a coincident expiry: no done.
            if (!w_drop)
              r_done <= r_grant;
            r_cnt <= '0;
            if (!w_any) begin
              r_state <= IDLE;
              r_grant <= '0;
              r_valid <= 1'b0;
            end
`ifdef DISP_ARB_BLANK_EN
            else if (w_pick != r_src) begin
              r_state <= BLANK;
              r_grant <= '0;
              r_valid <= 1'b0;
              r_value <= '0;
            end
`endif
            else begin
              r_grant <= w_pick_oh;
              r_src   <= w_pick;
              r_ptr   <= w_pick;
            end
          end else if (!lock) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef DISP_ARB_BLANK_EN
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_cnt <= '0;
            if (w_any) begin
              r_state <= SHOW;
              r_grant <= w_pick_oh;
              r_src   <= w_pick;
              r_ptr   <= w_pick;
              r_valid <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign disp_value = r_value;
  assign disp_src   = r_src;
  assign disp_valid = r_valid;
  assign done       = r_done;

endmodule

// File: tb/tb_disp_arbiter.sv
// Vector-table bench for disp_arbiter (NUM_SRC=4, DWELL=4, BLANK=2).
// Blank-gap vectors are included when DISP_ARB_BLANK_EN is defined.
module tb_disp_arbiter;

  localparam logic [63:0] DABC = 64'h000D_000C_000B_000A;
  localparam logic [63:0] S2A  = 64'hEEEE_1234_EEEE_EEEE;
  localparam logic [63:0] S2B  = 64'hEEEE_5678_EEEE_EEEE;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] src_data;
  logic        lock;
  logic [3:0]  grant;
  logic [15:0] disp_value;
  logic [1:0]  disp_src;
  logic        disp_valid;
  logic [3:0]  done;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        lock;
    logic [63:0] data;
    logic [3:0]  eg;
    logic [15:0] ev;
    logic        evld;
    logic [3:0]  ed;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t v;
  vec_t e;
  int   checks   = 0;
  int   failures = 0;

  disp_arbiter #(
    .NUM_SRC      (4),
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .src_data   (src_data),
    .lock       (lock),
    .grant      (grant),
    .disp_value (disp_value),
    .disp_src   (disp_src),
    .disp_valid (disp_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void add(
    input logic r, input logic [3:0] rq, input logic lk,
    input logic [63:0] d, input logic [3:0] g,
    input logic [15:0] val, input logic vl, input logic [3:0] dn
  );
    vec_t t;
    t.rst = r; t.req = rq; t.lock = lk; t.data = d;
    t.eg = g; t.ev = val; t.evld = vl; t.ed = dn;
    vecs.push_back(t);
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    idx_of = 2'd0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) idx_of = 2'(i);
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; req = '0; lock = 1'b0; src_data = DABC;

    // Reset, then rotation over all four sources.
    add(1'b0, 4'hF, 1'b0, DABC, 4'h0, 16'h0, 1'b0, 4'h0);
    for (int k = 1; k <= 21; k++)
      add(1'b1, 4'hF, 1'b0, DABC,
          4'(1 << (((k - 1) / 4) % 4)),
          (k == 1) ? 16'h0 : 16'h000A + 16'(((k - 2) / 4) % 4),
          1'b1,
          (k >= 5 && (k - 1) % 4 == 0) ?
            4'(1 << (((k - 1) / 4 - 1) % 4)) : 4'h0);

    // Single requester with a changing value.
    add(1'b0, 4'b0100, 1'b0, S2A, 4'h0, 16'h0, 1'b0, 4'h0);
    for (int k = 1; k <= 9; k++)
      add(1'b1, 4'b0100, 1'b0, (k < 6) ? S2A : S2B, 4'b0100,
          (k == 1) ? 16'h0 : ((k < 6) ? 16'h1234 : 16'h5678),
          1'b1, (k == 5 || k == 9) ? 4'b0100 : 4'h0);

    // Drop, coincident expiry+drop, then drop to idle.
    add(1'b0, 4'b0110, 1'b0, DABC, 4'h0,    16'h0, 1'b0, 4'h0);
    add(1'b1, 4'b0110, 1'b0, DABC, 4'b0010, 16'h0, 1'b1, 4'h0);
    add(1'b1, 4'b0110, 1'b0, DABC, 4'b0010, 16'hB, 1'b1, 4'h0);
    add(1'b1, 4'b0100, 1'b0, DABC, 4'b0100, 16'hB, 1'b1, 4'h0);
    add(1'b1, 4'b0100, 1'b0, DABC, 4'b0100, 16'hC, 1'b1, 4'h0);
    add(1'b1, 4'b0100, 1'b0, DABC, 4'b0100, 16'hC, 1'b1, 4'h0);
    add(1'b1, 4'b0100, 1'b0, DABC, 4'b0100, 16'hC, 1'b1, 4'h0);
    add(1'b1, 4'b0100, 1'b0, DABC, 4'b0100, 16'hC, 1'b1, 4'b0100);
    add(1'b1, 4'b0100, 1'b0, DABC, 4'b0100, 16'hC, 1'b1, 4'h0);
    add(1'b1, 4'b0100, 1'b0, DABC, 4'b0100, 16'hC, 1'b1, 4'h0);
    add(1'b1, 4'b0100, 1'b0, DABC, 4'b0100, 16'hC, 1'b1, 4'h0);
    add(1'b1, 4'b0001, 1'b0, DABC, 4'b0001, 16'hC, 1'b1, 4'h0);
    add(1'b1, 4'b0001, 1'b0, DABC, 4'b0001, 16'hA, 1'b1, 4'h0);
    add(1'b1, 4'b0000, 1'b0, DABC, 4'h0,    16'hA, 1'b0, 4'h0);
    add(1'b1, 4'b0000, 1'b0, DABC, 4'h0,    16'hA, 1'b0, 4'h0);

    // Lock at the last dwell count, then drop while locked.
    add(1'b0, 4'hF, 1'b0, DABC, 4'h0, 16'h0, 1'b0, 4'h0);
    add(1'b1, 4'hF, 1'b0, DABC, 4'b0001, 16'h0, 1'b1, 4'h0);
    for (int k = 2; k <= 24; k++)
      add(1'b1, 4'hF, (k >= 5), DABC, 4'b0001, 16'hA, 1'b1, 4'h0);
    add(1'b1, 4'hF,    1'b0, DABC, 4'b0010, 16'hA, 1'b1, 4'b0001);
    add(1'b1, 4'hF,    1'b0, DABC, 4'b0010, 16'hB, 1'b1, 4'h0);
    add(1'b1, 4'b1101, 1'b1, DABC, 4'b0100, 16'hB, 1'b1, 4'h0);
    add(1'b1, 4'b1101, 1'b0, DABC, 4'b0100, 16'hC, 1'b1, 4'h0);

`ifdef DISP_ARB_BLANK_EN
    add(1'b0, 4'b0001, 1'b0, DABC, 4'h0,    16'h0, 1'b0, 4'h0);
    add(1'b1, 4'b0001, 1'b0, DABC, 4'b0001, 16'h0, 1'b1, 4'h0);
    for (int k = 2; k <= 4; k++)
      add(1'b1, 4'b0001, 1'b0, DABC, 4'b0001, 16'hA, 1'b1, 4'h0);
    add(1'b1, 4'b0011, 1'b0, DABC, 4'h0,    16'h0, 1'b0, 4'b0001);
    add(1'b1, 4'b0011, 1'b0, DABC, 4'h0,    16'h0, 1'b0, 4'h0);
    add(1'b1, 4'b0011, 1'b0, DABC, 4'b0010, 16'h0, 1'b1, 4'h0);
    for (int k = 8; k <= 10; k++)
      add(1'b1, 4'b0011, 1'b0, DABC, 4'b0010, 16'hB, 1'b1, 4'h0);
    add(1'b1, 4'b0011, 1'b0, DABC, 4'h0,    16'h0, 1'b0, 4'b0010);
    add(1'b0, 4'b0011, 1'b0, DABC, 4'h0,    16'h0, 1'b0, 4'h0);
    add(1'b1, 4'b0001, 1'b0, DABC, 4'b0001, 16'h0, 1'b1, 4'h0);
    for (int k = 14; k <= 16; k++)
      add(1'b1, 4'b0001, 1'b0, DABC, 4'b0001, 16'hA, 1'b1, 4'h0);
    add(1'b1, 4'b0001, 1'b0, DABC, 4'b0001, 16'hA, 1'b1, 4'b0001);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst; req = v.req; lock = v.lock; src_data = v.data;
      exp_q.push_back(v);
      step();
      e = exp_q.pop_front();
      chk("grant",  i, 16'(grant),      16'(e.eg));
      chk("value",  i, disp_value,      e.ev);
      chk("valid",  i, 16'(disp_valid), 16'(e.evld));
      chk("done",   i, 16'(done),       16'(e.ed));
      chk("onehot", i, 16'($onehot0(grant)), 16'd1);
      if (e.eg != 4'h0)
        chk("src", i, 16'(disp_src), 16'(idx_of(e.eg)));
      else if (!e.rst)
        chk("src_rst", i, 16'(disp_src), 16'd0);
    end

    // Asynchronous reset in the middle of a dwell, between clock edges.
    rst = 1'b0; #1; rst = 1'b1;
    req = 4'hF; lock = 1'b0; src_data = DABC;
    repeat (3) step();
    chk("pre_async_grant", -1, 16'(grant), 16'h0001);
    chk("pre_async_value", -1, disp_value, 16'h000A);
    #3;
    rst = 1'b0;
    #1;
    chk("async_grant", -1, 16'(grant),      16'h0);
    chk("async_value", -1, disp_value,      16'h0);
    chk("async_valid", -1, 16'(disp_valid), 16'h0);
    chk("async_done",  -1, 16'(done),       16'h0);
    chk("async_src",   -1, 16'(disp_src),   16'h0);
    #2;
    rst = 1'b1;
    step();
    chk("post_async_grant", -1, 16'(grant),      16'h0001);
    chk("post_async_valid", -1, 16'(disp_valid), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
